gshare_predictor_spec: RTL and testbench

Parametrised gshare direction predictor for the pipelined core. It generalises the fixed 64-entry, 6-bit-history design with configurable PC, index and history widths. It also adds speculative global-history update at fetch, history repair on mispredict, and saturating statistics counters. Fetch queries it each cycle; the branch-resolve stage sends back the checkpointed index and history together with the actual outcome.

---
 rtl/gshare_predictor_spec.sv | 127 ++++++++++++
 tb/tb_gshare_predictor_spec.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor_spec.sv
// rtl/gshare_predictor_spec.sv - parametrised gshare direction predictor with speculative history and statistics
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pred_valid          fetch holds a branch; commits the speculative history shift
//   pred_pc             PC of the branch being predicted
//   pred_taken          combinational prediction (MSB of the indexed counter)
//   pred_idx            PHT index used for this prediction (carried to resolve)
//   pred_ghr            history value used for this prediction (checkpoint)
//   upd_valid           a resolved branch is present this cycle
//   upd_idx, upd_ghr    checkpointed index and history of the resolved branch
//   upd_taken           actual outcome of the resolved branch
//   upd_mispredict      resolved branch was mispredicted (qualified by upd_valid)
//   stat_branches       saturating count of resolved branches
//   stat_mispredicts    saturating count of mispredicted branches

module gshare_predictor_spec #(
    parameter int          PC_W     = 32,
    parameter int          PC_LSB   = 0,
    parameter int          IDX_W    = 6,
    parameter int          HIST_W   = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01,
    parameter int          STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]        r_pht [ENTRIES];
    logic [HIST_W-1:0] r_ghr;
    logic [STAT_W-1:0] r_stat_br;
    logic [STAT_W-1:0] r_stat_mis;

    logic [IDX_W-1:0]  w_ghr_ext;
    logic [IDX_W-1:0]  w_idx;
    logic              w_pred_taken;
    logic [HIST_W-1:0] w_ghr_next;
    logic              w_repair;
    logic              w_unused_pc;

    // PC bits outside the index window do not take part in the hash.
    assign w_unused_pc = ^pred_pc;

    // History occupies the low bits of the index; upper bits come from the PC only.
    always_comb begin
        w_ghr_ext               = '0;
        w_ghr_ext[HIST_W-1:0]   = r_ghr;
    end

    assign w_idx        = pred_pc[PC_LSB +: IDX_W] ^ w_ghr_ext;
    assign w_pred_taken = r_pht[w_idx][1];
    assign w_repair     = upd_valid & upd_mispredict;

    // Shift-left-then-insert keeps HIST_W=1 legal: the shift empties the
    // register and bit 0 receives the outcome.
    always_comb begin
        w_ghr_next = r_ghr;
        if (w_repair) begin
            w_ghr_next    = upd_ghr << 1;
            w_ghr_next[0] = upd_taken;
        end else if (pred_valid) begin
            w_ghr_next    = r_ghr << 1;
            w_ghr_next[0] = w_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (r_pht[upd_idx] != 2'd3) begin
                    r_pht[upd_idx] <= r_pht[upd_idx] + 2'd1;
                end
            end else begin
                if (r_pht[upd_idx] != 2'd0) begin
                    r_pht[upd_idx] <= r_pht[upd_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (upd_valid && (r_stat_br != '1)) begin
                r_stat_br <= r_stat_br + STAT_W'(1);
            end
            if (w_repair && (r_stat_mis != '1)) begin
                r_stat_mis <= r_stat_mis + STAT_W'(1);
            end
        end
    end

    assign pred_taken       = w_pred_taken;
    assign pred_idx         = w_idx;
    assign pred_ghr         = r_ghr;
    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;

endmodule

// File: tb/tb_gshare_predictor_spec.sv
// tb/tb_gshare_predictor_spec.sv - self-checking bench for gshare_predictor_spec

module tb_gshare_predictor_spec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic [5:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;

    logic        pred_taken, d2_pred_taken;
    logic [5:0]  pred_idx, d2_pred_idx;
    logic [5:0]  pred_ghr, d2_pred_ghr;
    logic [15:0] stat_branches, stat_mispredicts;
    logic [1:0]  d2_stat_branches, d2_stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_predictor_spec dut (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    gshare_predictor_spec #(.STAT_W(2)) dut2 (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(d2_pred_taken), .pred_idx(d2_pred_idx), .pred_ghr(d2_pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .stat_branches(d2_stat_branches), .stat_mispredicts(d2_stat_mispredicts)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counters as plain integers 0..3, history as an integer
    // masked to 6 bits, statistics as unbounded counts clamped on comparison.
    int  m_pht [64];
    int  m_ghr;
    int  m_br;
    int  m_mis;
    bit  model_ok = 1'b0;

    function automatic int m_index(input logic [31:0] pc);
        return (int'(pc) & 63) ^ m_ghr;
    endfunction

    always @(posedge clk) begin
        int t;
        if (reset) begin
            for (int i = 0; i < 64; i++) m_pht[i] = 1;
            m_ghr = 0; m_br = 0; m_mis = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            t = (m_pht[m_index(pred_pc)] >= 2) ? 1 : 0;
            if (upd_valid) begin
                if (upd_taken) m_pht[upd_idx] = (m_pht[upd_idx] < 3) ? m_pht[upd_idx] + 1 : 3;
                else           m_pht[upd_idx] = (m_pht[upd_idx] > 0) ? m_pht[upd_idx] - 1 : 0;
                m_br++;
                if (upd_mispredict) m_mis++;
            end
            if (upd_valid && upd_mispredict) m_ghr = ((int'(upd_ghr) * 2) + int'(upd_taken)) % 64;
            else if (pred_valid)             m_ghr = ((m_ghr * 2) + t) % 64;
        end
    end

    // Compare process: every cycle once the model is initialised.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("pred_idx",   pred_idx,   m_index(pred_pc));
            chk("pred_taken", pred_taken, (m_pht[m_index(pred_pc)] >= 2) ? 1 : 0);
            chk("pred_ghr",   pred_ghr,   m_ghr);
            chk("stat_br",    stat_branches,    (m_br  > 65535) ? 65535 : m_br);
            chk("stat_mis",   stat_mispredicts, (m_mis > 65535) ? 65535 : m_mis);
            chk("d2_stat_br",  d2_stat_branches,    (m_br  > 3) ? 3 : m_br);
            chk("d2_stat_mis", d2_stat_mispredicts, (m_mis > 3) ? 3 : m_mis);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pred_valid = 0; upd_valid = 0; upd_mispredict = 0; upd_taken = 0;
    endtask

    initial begin
        // Reset, then predict PC 5.
        tick();
        reset = 0; pred_pc = 5;
        at_neg();
        chk("lit_reset_idx",   pred_idx, 5);
        chk("lit_reset_taken", pred_taken, 0);
        chk("lit_reset_ghr",   pred_ghr, 0);
        chk("lit_reset_br",    stat_branches, 0);
        chk("lit_reset_mis",   stat_mispredicts, 0);

        // Train entry 5 taken four times: 1,2,3,3.
        tick();
        upd_valid = 1; upd_idx = 5; upd_taken = 1;
        tick();
        at_neg();
        chk("lit_train1_taken", pred_taken, 1);
        repeat (3) tick();
        upd_valid = 0;
        at_neg();
        chk("lit_train4_taken", pred_taken, 1);
        chk("lit_train4_br",    stat_branches, 4);
        chk("lit_d2_sat_br",    d2_stat_branches, 3);
        // Saturated at 3: one decrement still predicts taken, a second does not.
        tick();
        upd_valid = 1; upd_taken = 0;
        tick();
        upd_valid = 0;
        at_neg();
        chk("lit_dec1_taken", pred_taken, 1);
        tick();
        upd_valid = 1;
        tick();
        upd_valid = 0;
        at_neg();
        chk("lit_dec2_taken", pred_taken, 0);

        // Clean state, train entries 8 and 9 to strongly taken.
        tick();
        reset = 1;
        tick();
        reset = 0;
        upd_valid = 1; upd_taken = 1; upd_idx = 8;
        tick(); tick();
        upd_idx = 9;
        tick(); tick();
        upd_valid = 0;
        // Predictions 1 (pc 8 -> idx 8), 0 (pc 0 -> idx 1), 1 (pc 11 -> idx 9).
        pred_valid = 1; pred_pc = 8;
        tick();
        pred_pc = 0;
        tick();
        pred_pc = 11;
        tick();
        pred_valid = 0; pred_pc = 0;
        at_neg();
        chk("lit_spec_ghr", pred_ghr, 6'b000101);
        chk("lit_spec_idx", pred_idx, 5);

        // Repair wins over the same-cycle speculative shift.
        tick();
        upd_valid = 1; upd_mispredict = 1; upd_ghr = 6'b000010; upd_taken = 1; upd_idx = 20;
        pred_valid = 1; pred_pc = 0;
        tick();
        idle_inputs();
        at_neg();
        chk("lit_repair_ghr", pred_ghr, 6'b000101);
        chk("lit_repair_mis", stat_mispredicts, 1);
        chk("lit_repair_br",  stat_branches, 5);

        // Same-cycle read and write of entry 5 (counter 1).
        tick();
        pred_pc = 0; upd_valid = 1; upd_idx = 5; upd_taken = 1;
        at_neg();
        chk("lit_bypass_before", pred_taken, 0);
        tick();
        upd_valid = 0;
        at_neg();
        chk("lit_bypass_after", pred_taken, 1);

        // Reset overrides a same-cycle update.
        tick();
        reset = 1; upd_valid = 1; upd_idx = 5; upd_taken = 1;
        tick();
        reset = 0; upd_valid = 0; pred_pc = 5;
        at_neg();
        chk("lit_rst_upd_taken", pred_taken, 0);
        chk("lit_rst_upd_ghr",   pred_ghr, 0);
        chk("lit_rst_upd_br",    stat_branches, 0);
        chk("lit_rst_upd_d2br",  d2_stat_branches, 0);

        // Randomised traffic checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset          = ($urandom_range(0, 199) == 0);
            pred_valid     = $urandom_range(0, 1);
            pred_pc        = $urandom;
            upd_valid      = ($urandom_range(0, 3) != 0);
            upd_idx        = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            upd_ghr        = 6'($urandom);
            upd_taken      = $urandom_range(0, 1);
            upd_mispredict = ($urandom_range(0, 3) == 0);
        end
        tick();
        idle_inputs();
        reset = 0;
        at_neg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
